// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary registers: occupancy encoding,
// default bundle widths and control-field bit positions.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int DEF_DATA_W = 48;
    localparam int DEF_CTRL_W = 9;
    localparam int DEF_CNT_W  = 16;

    localparam int IFID_DATA_W  = 32;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 48;
    localparam int IDEX_CTRL_W  = 9;
    localparam int EXMEM_DATA_W = 48;
    localparam int EXMEM_CTRL_W = 9;
    localparam int MEMWB_DATA_W = 32;
    localparam int MEMWB_CTRL_W = 6;

    // Control bundle layout: writeRegSel occupies the low three bits.
    localparam int CTRL_WRSEL_LSB = 0;
    localparam int CTRL_WRSEL_MSB = 2;
    localparam int CTRL_REGWRITE  = 3;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_WRITER7   = 7;
    localparam int CTRL_HALT      = 8;

endpackage

// File: rtl/pipe_entry_reg.sv
// Enable register with synchronous reset, holding one {ctrl, data} entry.
module pipe_entry_reg #(
    parameter int           W       = 57,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline boundary register with a 2-entry skid buffer, flush-to-bubble and
// a saturating stall counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int               ENT_W   = DATA_W + CTRL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             head_en, skid_en;
    logic [ENT_W-1:0] in_ent, head_d, head_q, skid_q;
    logic             valid_w, accept, drain;

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; in_ready is a register so out_ready never reaches it.
    assign in_ent  = {in_ctrl, in_data};
    assign valid_w = (state_q != ST_EMPTY);
    assign accept  = in_valid & in_ready_q;
    assign drain   = valid_w & out_ready;

    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = in_ent;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        head_en = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        head_en = 1'b1;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_en = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_d = ST_FULL;
                        head_en = 1'b1;
                        head_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_w && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_SKID);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_entry_reg #(.W(ENT_W), .RST_VAL('0)) u_head (
        .clk (clk),
        .rst (rst),
        .en  (head_en),
        .d   (head_d),
        .q   (head_q)
    );

    pipe_entry_reg #(.W(ENT_W), .RST_VAL('0)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_ent),
        .q   (skid_q)
    );

    // Head data is left untouched when the stage empties, so only ctrl is masked.
    assign in_ready  = in_ready_q;
    assign out_valid = valid_w;
    assign out_data  = head_q[DATA_W-1:0];
    assign out_ctrl  = valid_w ? head_q[ENT_W-1:DATA_W] : CTRL_BUBBLE;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand-written
// saturation/reset sequence, then random traffic against a queue model.
module tb_pipe_skid_stage;

    localparam int DW = 48;
    localparam int CW = 9;
    localparam int NW = 4;
    localparam logic [NW-1:0] SMAX = '1;
    localparam logic [CW-1:0] CT   = 9'h018;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of {ctrl, data}, capacity 2.
    logic [CW+DW-1:0] exp_q[$];
    logic [DW-1:0]    m_last = '0;
    logic [NW-1:0]    m_stall = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, f, iv, input logic [DW-1:0] d,
                              input logic [CW-1:0] c, input logic ordy);
        logic acc, drn;
        if (r) begin
            exp_q.delete();
            m_stall = '0;
            m_last  = '0;
        end else begin
            acc = iv && (exp_q.size() < 2);
            drn = (exp_q.size() > 0) && ordy;
            if ((exp_q.size() > 0) && !ordy && !f && (m_stall != SMAX)) m_stall = m_stall + 1'b1;
            if (f) begin
                exp_q.delete();
            end else begin
                if (drn) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({c, d});
            end
            if (exp_q.size() > 0) m_last = exp_q[0][DW-1:0];
        end
    endtask

    task automatic apply(input logic r, f, iv, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        @(posedge clk);
        model_step(r, f, iv, d, c, ordy);
        #1;
    endtask

    task automatic check_model();
        logic [CW-1:0] ec;
        ec = (exp_q.size() > 0) ? exp_q[0][CW+DW-1:DW] : '0;
        chk("rnd_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("rnd_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("rnd_occ", 64'(occupancy), 64'(exp_q.size()));
        chk("rnd_data", 64'(out_data), 64'(m_last));
        chk("rnd_ctrl", 64'(out_ctrl), 64'(ec));
        chk("rnd_stall", 64'(stall_cnt), 64'(m_stall));
    endtask

    typedef struct {
        string         nm;
        logic          r, f, iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          ev, er;
        logic [1:0]    eo;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic [NW-1:0] es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic r, f, iv,
                                input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy,
                                input logic ev, er, input logic [1:0] eo,
                                input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                                input logic [NW-1:0] es);
        vec_t v;
        v.nm = nm; v.r = r; v.f = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.ev = ev; v.er = er; v.eo = eo; v.ed = ed; v.ec = ec; v.es = es;
        vecs.push_back(v);
    endfunction

    initial begin
        // Expected values are the outputs seen after the edge that consumes the row.
        add("rst0",       1, 0, 0, 0,      0,  0,  0, 1, 0, 0,      0,  0);
        add("rst1",       1, 0, 1, 48'h55, CT, 1,  0, 1, 0, 0,      0,  0);
        add("idle",       0, 0, 0, 0,      0,  1,  0, 1, 0, 0,      0,  0);
        for (int k = 1; k <= 8; k++)
            add("stream", 0, 0, 1, DW'(k), CT, 1,  1, 1, 1, DW'(k), CT, 0);
        add("drain_last", 0, 0, 0, 0,      0,  1,  0, 1, 0, 48'h8,  0,  0);
        add("bp_a1",      0, 0, 1, 48'hA1, CT, 0,  1, 1, 1, 48'hA1, CT, 0);
        add("bp_a2",      0, 0, 1, 48'hA2, CT, 0,  1, 0, 2, 48'hA1, CT, 1);
        add("bp_hold1",   0, 0, 1, 48'hA3, CT, 0,  1, 0, 2, 48'hA1, CT, 2);
        add("bp_hold2",   0, 0, 1, 48'hA3, CT, 0,  1, 0, 2, 48'hA1, CT, 3);
        add("bp_out_a2",  0, 0, 1, 48'hA3, CT, 1,  1, 1, 1, 48'hA2, CT, 3);
        add("bp_out_a3",  0, 0, 1, 48'hA3, CT, 1,  1, 1, 1, 48'hA3, CT, 3);
        add("bp_empty",   0, 0, 0, 0,      0,  1,  0, 1, 0, 48'hA3, 0,  3);
        add("fl_c1",      0, 0, 1, 48'hC1, CT, 0,  1, 1, 1, 48'hC1, CT, 3);
        add("fl_c2",      0, 0, 1, 48'hC2, CT, 0,  1, 0, 2, 48'hC1, CT, 4);
        add("fl_skid_bb", 0, 1, 1, 48'hBB, CT, 0,  0, 1, 0, 48'hC1, 0,  4);
        add("fl_idle",    0, 0, 0, 0,      0,  1,  0, 1, 0, 48'hC1, 0,  4);
        add("fl2_d0",     0, 0, 1, 48'hD0, CT, 1,  1, 1, 1, 48'hD0, CT, 4);
        add("fl2_full",   0, 1, 1, 48'hD1, CT, 1,  0, 1, 0, 48'hD0, 0,  4);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy);
            chk({vecs[i].nm, "_valid"}, 64'(out_valid), 64'(vecs[i].ev));
            chk({vecs[i].nm, "_ready"}, 64'(in_ready), 64'(vecs[i].er));
            chk({vecs[i].nm, "_occ"},   64'(occupancy), 64'(vecs[i].eo));
            chk({vecs[i].nm, "_data"},  64'(out_data), 64'(vecs[i].ed));
            chk({vecs[i].nm, "_ctrl"},  64'(out_ctrl), 64'(vecs[i].ec));
            chk({vecs[i].nm, "_stall"}, 64'(stall_cnt), 64'(vecs[i].es));
        end

        // Saturation: hold one entry under backpressure for 20 cycles.
        apply(0, 0, 1, 48'hE2, CT, 0);
        chk("sat_load_occ", 64'(occupancy), 64'd1);
        for (int i = 1; i <= 20; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            chk("sat_stall", 64'(stall_cnt), 64'((4 + i > 15) ? 15 : 4 + i));
            chk("sat_data_hold", 64'(out_data), 64'h0E2);
            chk("sat_ctrl_hold", 64'(out_ctrl), 64'(CT));
        end

        // Reset mid-stall together with flush and a live upstream entry.
        apply(1, 1, 1, 48'hF1, CT, 0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_occ",   64'(occupancy), 64'd0);
        chk("midrst_data",  64'(out_data), 64'd0);
        chk("midrst_ctrl",  64'(out_ctrl), 64'd0);
        chk("midrst_stall", 64'(stall_cnt), 64'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            logic r, f, iv, ordy;
            logic [DW-1:0] d;
            r    = ($urandom_range(0, 299) == 0);
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = {16'($urandom), $urandom};
            apply(r, f, iv, d, CW'($urandom_range(0, 511)), ordy);
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
